// File: rtl/data_mem_pkg.sv
// Shared definitions for the external data memory: response constants,
// FSM state encoding and the registered response-kind selector.
package data_mem_pkg;

  localparam logic [31:0] IDLE_VALUE = 32'hfa11_1eaf;
  localparam logic [31:0] OOR_VALUE  = 32'hdead_beef;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } data_mem_state_t;

  // Which source drives read_data_o; updated only when an access completes.
  typedef enum logic [1:0] {
    KIND_ZERO = 2'd0,
    KIND_READ = 2'd1,
    KIND_WACK = 2'd2,
    KIND_OOR  = 2'd3
  } data_mem_kind_t;

endpackage

// File: rtl/data_mem_array.sv
// Storage for the external data memory: byte-strobed synchronous write and
// registered synchronous read. No reset, no control logic.
module data_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORDS      = 1024,
  localparam int unsigned BYTES     = DATA_WIDTH / 8,
  localparam int unsigned IDX_BITS  = $clog2(WORDS)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [BYTES-1:0]      be_i,
  input  logic [IDX_BITS-1:0]   idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-strobed write and registered read of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_data_mem.sv
// Multi-cycle data memory for the LSU: request latch, latency counter,
// IDLE/WAIT/RESP FSM, range check and response mux around data_mem_array.
// Optional feature macro: DATA_MEM_ACCESS_FAULT_EN adds fault_o, flagging
// out-of-range or misaligned accesses alongside ready_o.
module ext_data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_req_i,
  input  logic                    write_enable_i,
  input  logic [DATA_WIDTH/8-1:0] byte_enable_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  output logic [DATA_WIDTH-1:0]   read_data_o,
`ifdef DATA_MEM_ACCESS_FAULT_EN
  output logic                    fault_o,
`endif
  output logic                    ready_o
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned ADDR_BITS = $clog2(DEPTH_BYTES);
  localparam int unsigned OFF_BITS  = $clog2(BYTES);
  localparam int unsigned IDX_BITS  = ADDR_BITS - OFF_BITS;
  localparam int unsigned WORDS     = DEPTH_BYTES / BYTES;
  localparam int unsigned CNT_BITS  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  // Replicate or truncate a 32-bit response constant to the word width.
  function automatic logic [DATA_WIDTH-1:0] fit_word(input logic [31:0] c);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      r[i] = c[i % 32];
    end
    return r;
  endfunction

  data_mem_state_t       state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [BYTES-1:0]      be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic                  in_range_q, in_range_d;
  data_mem_kind_t        kind_q, kind_d;
  logic                  ready_q, ready_d;

  logic                  in_range_s;
  logic [IDX_BITS-1:0]   idx_s;
  logic                  fire_s;
  logic                  acc_we_s;
  logic [BYTES-1:0]      acc_be_s;
  logic [DATA_WIDTH-1:0] acc_wdata_s;
  logic [IDX_BITS-1:0]   acc_idx_s;
  logic                  acc_in_range_s;
  logic                  arr_we_s;
  logic                  arr_re_s;
  logic [DATA_WIDTH-1:0] arr_rdata_s;

  assign in_range_s = ({1'b0, addr_i} < 33'(DEPTH_BYTES));
  assign idx_s      = addr_i[ADDR_BITS-1:OFF_BITS];

`ifdef DATA_MEM_ACCESS_FAULT_EN
  logic misal_s;
  logic misal_q, misal_d;
  logic acc_misal_s;
  logic fault_q, fault_d;
  assign misal_s = ((addr_i & 32'(BYTES - 1)) != 32'd0);
`endif

  // Access operands: the latched request while waiting, else the live inputs
  // (the zero-latency case performs the access on the acceptance edge).
  always_comb begin
    if (state_q == WAIT) begin
      acc_we_s       = we_q;
      acc_be_s       = be_q;
      acc_wdata_s    = wdata_q;
      acc_idx_s      = idx_q;
      acc_in_range_s = in_range_q;
    end else begin
      acc_we_s       = write_enable_i;
      acc_be_s       = byte_enable_i;
      acc_wdata_s    = write_data_i;
      acc_idx_s      = idx_s;
      acc_in_range_s = in_range_s;
    end
`ifdef DATA_MEM_ACCESS_FAULT_EN
    if (state_q == WAIT) begin
      acc_misal_s = misal_q;
    end else begin
      acc_misal_s = misal_s;
    end
`endif
  end

  // Next-state, counter, request latch and response-kind logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    kind_d     = kind_q;
    fire_s     = 1'b0;
`ifdef DATA_MEM_ACCESS_FAULT_EN
    misal_d    = misal_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        if (mem_req_i) begin
          we_d       = write_enable_i;
          be_d       = byte_enable_i;
          wdata_d    = write_data_i;
          idx_d      = idx_s;
          in_range_d = in_range_s;
`ifdef DATA_MEM_ACCESS_FAULT_EN
          misal_d    = misal_s;
`endif
          if (LATENCY == 0) begin
            state_d = RESP;
            fire_s  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_BITS'(LATENCY);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // The access completes as the counter reaches zero.
        if (cnt_q <= CNT_BITS'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
          fire_s  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (fire_s) begin
      if (acc_we_s) begin
        kind_d = KIND_WACK;
      end else if (acc_in_range_s) begin
        kind_d = KIND_READ;
      end else begin
        kind_d = KIND_OOR;
      end
    end else begin
      kind_d = kind_q;
    end

    ready_d = (state_d == RESP);
`ifdef DATA_MEM_ACCESS_FAULT_EN
    fault_d = fire_s & (~acc_in_range_s | acc_misal_s);
`endif
  end

  // Reset takes priority so a pending access can never reach the array.
  assign arr_we_s = fire_s & acc_we_s & acc_in_range_s & ~rst_i;
  assign arr_re_s = fire_s & ~acc_we_s & acc_in_range_s & ~rst_i;

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      kind_q     <= KIND_ZERO;
      ready_q    <= 1'b0;
`ifdef DATA_MEM_ACCESS_FAULT_EN
      misal_q    <= 1'b0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      kind_q     <= kind_d;
      ready_q    <= ready_d;
`ifdef DATA_MEM_ACCESS_FAULT_EN
      misal_q    <= misal_d;
      fault_q    <= fault_d;
`endif
    end
  end

  data_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we_s),
    .re_i    (arr_re_s),
    .be_i    (acc_be_s),
    .idx_i   (acc_idx_s),
    .wdata_i (acc_wdata_s),
    .rdata_o (arr_rdata_s)
  );

  // Response mux: every source is a register, so the data only moves on the
  // edge that completes an access.
  always_comb begin
    case (kind_q)
      KIND_READ: read_data_o = arr_rdata_s;
      KIND_WACK: read_data_o = fit_word(IDLE_VALUE);
      KIND_OOR:  read_data_o = fit_word(OOR_VALUE);
      default:   read_data_o = '0;
    endcase
  end

  assign ready_o = ready_q;
`ifdef DATA_MEM_ACCESS_FAULT_EN
  assign fault_o = fault_q;
`endif

endmodule

// File: tb/tb_ext_data_mem.sv
// Directed self-checking bench for ext_data_mem with default parameters.
module tb_ext_data_mem;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
`ifdef DATA_MEM_ACCESS_FAULT_EN
  logic        fault;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  ext_data_mem dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_req_i      (req),
    .write_enable_i (we),
    .byte_enable_i  (be),
    .addr_i         (addr),
    .write_data_i   (wdata),
    .read_data_o    (rdata),
`ifdef DATA_MEM_ACCESS_FAULT_EN
    .fault_o        (fault),
`endif
    .ready_o        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated access; the acceptance cycle is cycle 0, ready expected in cycle 3.
  task automatic access(input string tag, input logic w, input logic [3:0] strobe,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_fault);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; be = strobe; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n = 1;
    while (ready !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_data"}, rdata, exp_data);
`ifdef DATA_MEM_ACCESS_FAULT_EN
    chk({tag, "_fault"}, {31'd0, fault}, {31'd0, exp_fault});
`else
    if (exp_fault !== 1'b0 && exp_fault !== 1'b1) begin
      chk({tag, "_fault_arg"}, {31'd0, exp_fault}, 32'd0);
    end
`endif
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, ready}, 32'd0);
    chk({tag, "_hold"}, rdata, exp_data);
  endtask

  initial begin
    rst = 1'b1; req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;

    // Reset held with a request pending: nothing accepted, outputs cleared.
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end
    rst = 1'b0; req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_accept", {31'd0, ready}, 32'd0);
    end

    // Write then read back.
    access("wr0", 1'b1, 4'hF, 32'h0, 32'h7654_3210, 32'hfa11_1eaf, 1'b0);
    access("rd0", 1'b0, 4'h0, 32'h0, 32'h0, 32'h7654_3210, 1'b0);

    // Byte strobes: lanes 0 and 2 only.
    access("wr_strb", 1'b1, 4'b0101, 32'h0, 32'hAABB_CCDD, 32'hfa11_1eaf, 1'b0);
    access("rd_strb", 1'b0, 4'h0, 32'h0, 32'h0, 32'h76BB_32DD, 1'b0);

    // Out of range handling; 0x1000 would alias word 0 if the range check failed.
    access("rd_oor", 1'b0, 4'h0, 32'h1000, 32'h0, 32'hdead_beef, 1'b1);
    access("wr_top", 1'b1, 4'hF, 32'hFFC, 32'hCAFE_F00D, 32'hfa11_1eaf, 1'b0);
    access("wr_oor", 1'b1, 4'hF, 32'h1000, 32'h1234_5678, 32'hfa11_1eaf, 1'b1);
    access("rd_top", 1'b0, 4'h0, 32'hFFC, 32'h0, 32'hCAFE_F00D, 1'b0);
    access("rd_w0", 1'b0, 4'h0, 32'h0, 32'h0, 32'h76BB_32DD, 1'b0);

    // Reset in the first WAIT cycle aborts a write.
    access("wr4", 1'b1, 4'hF, 32'h4, 32'h2222_2222, 32'hfa11_1eaf, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h4; wdata = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_pulse", {31'd0, ready}, 32'd0);
    end
    access("rd4", 1'b0, 4'h0, 32'h4, 32'h0, 32'h2222_2222, 1'b0);

    // Back-to-back reads with the request held high.
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    addr = 32'h4;
    lat = 1;
    while (ready !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_cycle", 32'(lat), 32'd3);
    chk("b2b_first_data", rdata, 32'h76BB_32DD);
    @(negedge clk);
    req = 1'b0;
    lat++;
    chk("b2b_gap", {31'd0, ready}, 32'd0);
    while (ready !== 1'b1 && lat < 15) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_second_cycle", 32'(lat), 32'd6);
    chk("b2b_second_data", rdata, 32'h2222_2222);
    @(negedge clk);
    chk("b2b_end", {31'd0, ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_data_mem.md
# ext_data_mem

Parametrised, multi-cycle data memory for the RISC-V core's load/store path. It supersedes the single-cycle data memory and adds configurable depth and width, per-byte write strobes, a programmable access latency and a `ready_o` completion handshake. The core's LSU issues a request on `mem_req_i` and stalls until `ready_o`.

## Interface
- `DATA_WIDTH`, 32: word width in bits; multiple of 8.
- `DEPTH_BYTES`, 4096: capacity in bytes; power of two.
- `LATENCY`, 2: wait cycles between acceptance and response; 0 allowed.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `mem_req_i`  in  1  request valid.
- `write_enable_i`  in  1  1 = write, 0 = read.
- `byte_enable_i`  in  DATA_WIDTH/8  write byte strobes; ignored on reads.
- `addr_i`  in  32  byte address.
- `write_data_i`  in  DATA_WIDTH  write data.
- `read_data_o`  out  DATA_WIDTH  response data.
- `ready_o`  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, WAIT and RESP. Reset state is IDLE.
- Acceptance happens in IDLE or RESP when `mem_req_i`=1. The block latches addr, we, byte_enable and wdata. Inputs are ignored in WAIT.
- After acceptance, the FSM goes to WAIT with the counter loaded to LATENCY. If LATENCY=0, it goes straight to RESP.
- WAIT: the counter decrements each cycle. At 0 the access is performed and the FSM moves to RESP.
- RESP: `ready_o`=1 for exactly this cycle. The next state is WAIT or RESP if a new request is accepted this cycle, otherwise IDLE.
- Word index is `addr[$clog2(DEPTH_BYTES)-1 : $clog2(DATA_WIDTH/8)]`. Low address bits are ignored.
- In range means `addr_i < DEPTH_BYTES`.
- Write, in range: bytes with strobe=1 are updated and the other bytes keep their value. `read_data_o`=32'hfa11_1eaf in RESP.
- Write, out of range: dropped. `read_data_o`=32'hfa11_1eaf.
- Read, in range: `read_data_o` = stored word.
- Read, out of range: `read_data_o`=32'hdead_beef.
- For DATA_WIDTH≠32, the constants are replicated or truncated to DATA_WIDTH.
- Storage is not initialised and not cleared by reset; unwritten words read as X.
- `read_data_o` holds its value outside RESP until the next response.

## Timing
- Reset values: `ready_o`=0, `read_data_o`=0, FSM=IDLE, counter=0.
- Response latency: `ready_o` rises LATENCY+1 cycles after the acceptance edge.
- Throughput: with `mem_req_i` held high, one access every LATENCY+1 cycles.
- Read data is synchronous: `read_data_o` changes only on a clock edge entering RESP and is never combinational from `addr_i`.
- Reset mid-operation (WAIT or RESP):
  - the pending access is aborted and no write is committed;
  - `ready_o`=0 on the next cycle;
  - the FSM returns to IDLE.
- Simultaneous `rst_i` and `mem_req_i`: reset wins and the request is not accepted.
- A write followed by a read to the same word returns the new data, because accesses are serialised.

## Configuration
- `DATA_MEM_ACCESS_FAULT_EN` defined:
  - adds output `fault_o` (1 bit, reset 0);
  - `fault_o` is asserted together with `ready_o` for an out-of-range access, or for a misaligned address (`addr_i` low bits ≠0).
  - A misaligned access still completes as if aligned.
- Undefined: no `fault_o` port; misaligned addresses silently ignore the low bits.

## Structure
- Package `data_mem_pkg` holds:
  - `IDLE_VALUE`=32'hfa11_1eaf;
  - `OOR_VALUE`=32'hdead_beef;
  - the FSM state enum `data_mem_state_t` (IDLE, WAIT, RESP).
- Sub-module `data_mem_array` is the storage. It has a byte-strobed synchronous write and a synchronous read, is parametrised by DATA_WIDTH and word count, and contains no control logic.
- The top level holds the FSM, the latency counter, the request latch, range and fault checks, and the output mux.

## Test plan
All scenarios use the default parameters (32-bit, 4096 bytes, LATENCY=2).
- **Reset:** `rst_i`=1 for 2 cycles with `mem_req_i`=1 → `ready_o`=0, `read_data_o`=0, no acceptance.
- **Write then read:**
  - write 0x7654_3210 at 0x0, strobe 4'hF → `ready_o` exactly 3 cycles after acceptance, `read_data_o`=fa11_1eaf;
  - read 0x0 → 0x7654_3210.
- **Byte strobes:** write 0xAABB_CCDD at 0x0 with strobe 4'b0101 → read 0x0 returns 0x76BB_32DD.
- **Out of range:**
  - read 0x1000 → dead_beef;
  - write 0x1234_5678 to 0x1000, then read 0xFFC → unchanged;
  - with the macro defined, `fault_o`=1 together with `ready_o`.
- **Reset mid-op:** write 0x1111_1111 to 0x4, assert `rst_i` in the first WAIT cycle → no `ready_o` pulse; a later read of 0x4 returns its previous value.
- **Back-to-back:** hold `mem_req_i`=1 with reads of 0x0 then 0x4 → `ready_o` pulses 3 and 6 cycles after the first acceptance, returning the correct data each time.
